// File: rtl/sata_cmd_pkg.sv
// Shared definitions for the SATA host command sequencer: shadow-register map,
// completion codes, FSM states and the command descriptor layout.
package sata_cmd_pkg;

    localparam logic [4:0] ADDR_FEAT_CNT = 5'h01;
    localparam logic [4:0] ADDR_LBA_LO   = 5'h02;
    localparam logic [4:0] ADDR_LBA_HI   = 5'h03;
    localparam logic [4:0] ADDR_CMD_STAT = 5'h07;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DEVICE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LINK    = 2'd3;

    localparam int STAT_ERR = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_FEAT,
        ST_WR_LBA_LO,
        ST_WR_LBA_HI,
        ST_WR_CMD,
        ST_WAIT_IPF,
        ST_RD_STATUS,
        ST_RD_WAIT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [47:0] lba;
        logic [15:0] count;
        logic [15:0] features;
        logic [7:0]  device;
    } cmd_desc_t;

    // Shadow address presented while the FSM sits in a given state.
    function automatic logic [4:0] shadow_addr(input state_e st);
        case (st)
            ST_WR_FEAT:   return ADDR_FEAT_CNT;
            ST_WR_LBA_LO: return ADDR_LBA_LO;
            ST_WR_LBA_HI: return ADDR_LBA_HI;
            ST_WR_CMD,
            ST_RD_STATUS: return ADDR_CMD_STAT;
            default:      return 5'h00;
        endcase
    endfunction

    function automatic logic [31:0] shadow_data(input state_e st, input cmd_desc_t d);
        case (st)
            ST_WR_FEAT:   return {d.features, d.count};
            ST_WR_LBA_LO: return d.lba[31:0];
            ST_WR_LBA_HI: return {8'h00, d.device, d.lba[47:32]};
            ST_WR_CMD:    return {24'h0, d.opcode};
            default:      return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/sata_cmd_sequencer.sv
// Issues one ATA command through the sata_top shadow-register port, waits for
// the interrupt-pending flag, reads back status/error and reports completion.
module sata_cmd_sequencer
    import sata_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 150_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [47:0] cmd_lba,
    input  logic [15:0] cmd_count,
    input  logic [15:0] cmd_features,
    input  logic [7:0]  cmd_device,
    input  logic        cmd_dma,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [7:0]  rsp_status,
    output logic [7:0]  rsp_error,
    input  logic        linkup,
    input  logic        ipf,
    output logic        host_write_en,
    output logic        host_read_en,
    output logic [4:0]  host_addr_reg,
    output logic [31:0] host_data_in,
    input  logic [31:0] host_data_out,
    input  logic        write_hold,
    output logic        dma_rqst
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [1:0]       err_d;
    cmd_desc_t        desc_q, desc_src;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_phase_q;
    logic             accept;
    logic             unused_data_hi;

    assign cmd_ready      = (state_q == ST_IDLE) && linkup;
    assign accept         = cmd_valid && cmd_ready;
    assign unused_data_hi = ^host_data_out[31:16];

    // The write strobe is the registered write phase gated by write_hold, so a
    // held cycle never shows a strobe while address/data stay parked.
    assign host_write_en = wr_phase_q && !write_hold;

    // Descriptor feeding the shadow data: live inputs in the accept cycle so
    // the first write word is ready one cycle later.
    always_comb begin
        desc_src = desc_q;
        if (accept) begin
            desc_src = '{opcode: cmd_opcode, lba: cmd_lba, count: cmd_count,
                         features: cmd_features, device: cmd_device};
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        err_d   = ERR_OK;
        if (state_q != ST_IDLE && state_q != ST_DONE && !linkup) begin
            state_d = ST_DONE;
            err_d   = ERR_LINK;
        end else begin
            case (state_q)
                ST_IDLE:      if (accept)      state_d = ST_WR_FEAT;
                ST_WR_FEAT:   if (!write_hold) state_d = ST_WR_LBA_LO;
                ST_WR_LBA_LO: if (!write_hold) state_d = ST_WR_LBA_HI;
                ST_WR_LBA_HI: if (!write_hold) state_d = ST_WR_CMD;
                ST_WR_CMD:    if (!write_hold) state_d = ST_WAIT_IPF;
                ST_WAIT_IPF: begin
                    if (ipf) begin
                        state_d = ST_RD_STATUS;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_RD_STATUS: state_d = ST_RD_WAIT;
                ST_RD_WAIT: begin
                    state_d = ST_DONE;
                    err_d   = host_data_out[STAT_ERR] ? ERR_DEVICE : ERR_OK;
                end
                ST_DONE:      state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state and registered outputs update with non-blocking assignments so
    // every register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            desc_q        <= '0;
            cnt_q         <= '0;
            wr_phase_q    <= 1'b0;
            host_read_en  <= 1'b0;
            host_addr_reg <= '0;
            host_data_in  <= '0;
            done          <= 1'b0;
            err_code      <= ERR_OK;
            rsp_status    <= '0;
            rsp_error     <= '0;
            dma_rqst      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_phase_q    <= state_d inside {ST_WR_FEAT, ST_WR_LBA_LO, ST_WR_LBA_HI, ST_WR_CMD};
            host_read_en  <= (state_d == ST_RD_STATUS);
            host_addr_reg <= shadow_addr(state_d);
            host_data_in  <= shadow_data(state_d, desc_src);
            done          <= (state_d == ST_DONE);

            if (accept) desc_q <= desc_src;

            // Counts only while waiting; saturates instead of wrapping.
            if (state_q != ST_WAIT_IPF) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept) begin
                dma_rqst <= cmd_dma;
            end else if (state_d == ST_DONE) begin
                dma_rqst <= 1'b0;
            end

            if (state_d == ST_DONE) begin
                err_code <= err_d;
                if (state_q == ST_RD_WAIT && err_d != ERR_LINK) begin
                    rsp_status <= host_data_out[7:0];
                    rsp_error  <= host_data_out[15:8];
                end else begin
                    rsp_status <= '0;
                    rsp_error  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Self-checking bench for sata_cmd_sequencer: a vector table of commands with
// expected completions checked through a scoreboard, plus a mid-command reset.
module tb_sata_cmd_sequencer;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] GARBAGE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [47:0] cmd_lba;
    logic [15:0] cmd_count, cmd_features;
    logic [7:0]  cmd_device;
    logic        cmd_dma;
    logic        done;
    logic [1:0]  err_code;
    logic [7:0]  rsp_status, rsp_error;
    logic        linkup, ipf;
    logic        host_write_en, host_read_en;
    logic [4:0]  host_addr_reg;
    logic [31:0] host_data_in, host_data_out;
    logic        write_hold;
    logic        dma_rqst;

    always #5 clk = ~clk;

    sata_cmd_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_lba(cmd_lba), .cmd_count(cmd_count),
        .cmd_features(cmd_features), .cmd_device(cmd_device), .cmd_dma(cmd_dma),
        .done(done), .err_code(err_code), .rsp_status(rsp_status), .rsp_error(rsp_error),
        .linkup(linkup), .ipf(ipf),
        .host_write_en(host_write_en), .host_read_en(host_read_en),
        .host_addr_reg(host_addr_reg), .host_data_in(host_data_in),
        .host_data_out(host_data_out), .write_hold(write_hold), .dma_rqst(dma_rqst)
    );

    typedef struct {
        logic [7:0]  opcode;
        logic [47:0] lba;
        logic [15:0] count;
        logic [15:0] features;
        logic [7:0]  device;
        logic        dma;
        logic [31:0] rd_word;
        int          ipf_cycle;   // 0 = never
        int          hold_start;
        int          hold_len;
        int          link_drop;   // 0 = link stays up
        int          link_len;
        logic [1:0]  exp_err;
        logic [7:0]  exp_status;
        logic [7:0]  exp_error;
        int          exp_done;
    } vec_t;

    typedef struct packed {
        logic [1:0]  err;
        logic [7:0]  status;
        logic [7:0]  error;
        logic [31:0] cycle;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [47:0] lba, input logic [15:0] cnt,
                                input logic [15:0] feat, input logic [7:0] dev, input logic dma,
                                input logic [31:0] rdw, input int ipf_c, input int hs, input int hl,
                                input int ld, input int ll, input logic [1:0] err,
                                input logic [7:0] st, input logic [7:0] er, input int dc);
        vec_t v;
        v.opcode = op;  v.lba = lba;  v.count = cnt;  v.features = feat;  v.device = dev;
        v.dma = dma;  v.rd_word = rdw;  v.ipf_cycle = ipf_c;  v.hold_start = hs;  v.hold_len = hl;
        v.link_drop = ld;  v.link_len = ll;  v.exp_err = err;  v.exp_status = st;
        v.exp_error = er;  v.exp_done = dc;
        return v;
    endfunction

    function automatic bit in_hold(input vec_t v, input int c);
        return (v.hold_len != 0) && (c >= v.hold_start) && (c < v.hold_start + v.hold_len);
    endfunction

    task automatic drive_desc(input vec_t v);
        cmd_opcode   = v.opcode;
        cmd_lba      = v.lba;
        cmd_count    = v.count;
        cmd_features = v.features;
        cmd_device   = v.device;
        cmd_dma      = v.dma;
    endtask

    task automatic scramble_desc();
        cmd_opcode   = 8'($urandom);
        cmd_lba      = {16'($urandom), $urandom};
        cmd_count    = 16'($urandom);
        cmd_features = 16'($urandom);
        cmd_device   = 8'($urandom);
        cmd_dma      = 1'($urandom);
    endtask

    // Cycle 0 is the accept cycle; cycle c is sampled 2 time units after the c-th edge.
    task automatic run_vec(input int id, input vec_t v);
        logic [4:0]  ea[4];
        logic [31:0] ed[4];
        int          ec[4];
        int          p, widx, rd_at, done_at, link_end;
        bit          done_seen, rd_seen, rd_expected;
        exp_t        e;
        string       tag;

        tag = $sformatf("v%0d", id);
        ea  = '{5'h01, 5'h02, 5'h03, 5'h07};
        ed[0] = {v.features, v.count};
        ed[1] = v.lba[31:0];
        ed[2] = {8'h00, v.device, v.lba[47:32]};
        ed[3] = {24'h0, v.opcode};
        p = 1;
        for (int i = 0; i < 4; i++) begin
            while (in_hold(v, p)) p++;
            ec[i] = p;
            p++;
        end
        link_end    = (v.link_drop != 0) ? v.link_drop + v.link_len - 1 : 0;
        rd_expected = (v.ipf_cycle != 0) && (v.link_drop == 0);

        @(posedge clk); #1;
        linkup = 1'b1; write_hold = 1'b0; ipf = 1'b0; host_data_out = GARBAGE;
        drive_desc(v);
        cmd_valid = 1'b1;
        #1;
        check({tag, " accept_ready"}, cmd_ready, 1'b1);
        e.err = v.exp_err; e.status = v.exp_status; e.error = v.exp_error; e.cycle = v.exp_done;
        sb_q.push_back(e);

        widx = 0; rd_at = -10; done_at = 0; done_seen = 0; rd_seen = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            scramble_desc();
            write_hold    = in_hold(v, c);
            ipf           = (v.ipf_cycle != 0) && (c >= v.ipf_cycle) && (c <= v.ipf_cycle + 1);
            linkup        = !((v.link_drop != 0) && (c >= v.link_drop) && (c <= link_end));
            host_data_out = (c == rd_at + 1) ? v.rd_word : GARBAGE;
            #1;

            check({tag, " wr_rd_exclusive"}, host_write_en && host_read_en, 1'b0);
            if (write_hold && widx < 4) begin
                check({tag, " hold_no_write"}, host_write_en, 1'b0);
                check({tag, " hold_addr"}, host_addr_reg, ea[widx]);
                check({tag, " hold_data"}, host_data_in, ed[widx]);
            end
            if (host_write_en) begin
                if (widx < 4) begin
                    check({tag, $sformatf(" wr%0d_addr", widx)}, host_addr_reg, ea[widx]);
                    check({tag, $sformatf(" wr%0d_data", widx)}, host_data_in, ed[widx]);
                    check({tag, $sformatf(" wr%0d_cycle", widx)}, c, ec[widx]);
                end else begin
                    check({tag, " extra_write"}, host_write_en, 1'b0);
                end
                widx++;
            end
            if (host_read_en) begin
                if (rd_expected) begin
                    check({tag, " rd_cycle"}, c, v.ipf_cycle + 1);
                    check({tag, " rd_addr"}, host_addr_reg, 5'h07);
                    rd_seen = 1;
                    rd_at   = c;
                end else begin
                    check({tag, " no_read"}, host_read_en, 1'b0);
                end
            end
            if (c == 1) check({tag, " dma_rqst"}, dma_rqst, v.dma);

            if (done) begin
                if (sb_q.size() == 0) begin
                    check({tag, " unexpected_done"}, done, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, " done_cycle"}, c, e.cycle);
                    check({tag, " err_code"}, err_code, e.err);
                    check({tag, " rsp_status"}, rsp_status, e.status);
                    check({tag, " rsp_error"}, rsp_error, e.error);
                    check({tag, " dma_at_done"}, dma_rqst, 1'b0);
                end
                done_seen = 1;
                done_at   = c;
            end else if (done_seen && c > done_at) begin
                check({tag, " ready_after_done"}, cmd_ready, linkup);
            end
            if (done_seen && c > done_at && c > link_end) break;
        end

        if (!done_seen) check({tag, " done_seen"}, done_seen, 1'b1);
        sb_q.delete();
        check({tag, " write_count"}, widx, 4);
        if (rd_expected) check({tag, " read_seen"}, rd_seen, 1'b1);
    endtask

    initial begin
        vecs[0] = mk(8'h25, 48'h0000_1234_5678, 16'd8, 16'h0000, 8'h40, 1'b1, 32'h0000_0050,
                     10, 0, 0, 0, 0, 2'd0, 8'h50, 8'h00, 13);
        vecs[1] = mk(8'h25, 48'h0000_1234_5678, 16'd8, 16'h0000, 8'h40, 1'b1, 32'h0000_0050,
                     13, 2, 3, 0, 0, 2'd0, 8'h50, 8'h00, 16);
        vecs[2] = mk(8'hEC, 48'h0, 16'd1, 16'h0000, 8'hA0, 1'b0, 32'h0000_0451,
                     5, 0, 0, 0, 0, 2'd1, 8'h51, 8'h04, 8);
        vecs[3] = mk(8'h35, 48'hABCD_0000_1000, 16'h0100, 16'h00FF, 8'hE0, 1'b1, 32'h0000_0050,
                     0, 0, 0, 0, 0, 2'd2, 8'h00, 8'h00, 21);
        vecs[4] = mk(8'h25, 48'h0000_0000_0001, 16'hFFFF, 16'h1234, 8'h40, 1'b1, 32'hABCD_1250,
                     20, 0, 0, 0, 0, 2'd0, 8'h50, 8'h12, 23);
        vecs[5] = mk(8'hC8, 48'h0000_00AB_CDEF, 16'd4, 16'h0000, 8'hE0, 1'b0, 32'h0000_0451,
                     10, 0, 0, 10, 5, 2'd3, 8'h00, 8'h00, 11);

        rst_n = 1'b0; linkup = 1'b0; ipf = 1'b0; write_hold = 1'b0; cmd_valid = 1'b0;
        host_data_out = GARBAGE;
        drive_desc(vecs[0]);
        #2;
        check("rst_write_en", host_write_en, 1'b0);
        check("rst_read_en", host_read_en, 1'b0);
        check("rst_addr", host_addr_reg, 5'h00);
        check("rst_data", host_data_in, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_code, 2'd0);
        check("rst_status", {rsp_error, rsp_status}, 16'h0);
        check("rst_dma", dma_rqst, 1'b0);
        check("rst_ready_linkdown", cmd_ready, 1'b0);
        linkup = 1'b1;
        #1;
        check("rst_ready_linkup", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset pulse while WR_LBA_HI is on the bus, then a clean command.
        @(posedge clk); #1;
        linkup = 1'b1; write_hold = 1'b0; ipf = 1'b0;
        drive_desc(vecs[0]);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble_desc();
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_addr", host_addr_reg, 5'h03);
        check("pre_rst_write_en", host_write_en, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_write_en", host_write_en, 1'b0);
        check("async_rst_addr", host_addr_reg, 5'h00);
        check("async_rst_data", host_data_in, 32'h0);
        check("async_rst_dma", dma_rqst, 1'b0);
        check("async_rst_read_en", host_read_en, 1'b0);
        check("async_rst_ready", cmd_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(6, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
